smm_coo_tx: RTL and testbench

Dense-to-sparse (COO) stream encoder that feeds the Sparse Matrix Multiplier operand ports. It accepts a frame size, then a dense matrix in raster order (one 4-bit element per handshake). It emits every nonzero element as a (row, col, val) triplet through an elastic FIFO, tagging the final triplet with `out_last`. It is the transmitter side of the SMM `in_valid_size` / `in_valid_a` / `in_valid_b` interface; one instance drives each operand.

---
 rtl/smm_coo_tx_if.sv | 36 +++
 rtl/smm_coo_tx.sv | 156 +++++++++++++++
 tb/tb_smm_coo_tx.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smm_coo_tx_if.sv
// smm_coo_tx_if: bus bundle for the dense-to-COO encoder.
//   Dense input side : in_valid_size, in_size, in_valid, in_ready, in_val
//   Size toward SMM  : out_valid_size, out_size
//   Triplet output   : out_valid, out_ready, out_row, out_col, out_val, out_last
//   Status           : nnz_cnt, done
// modport master is the encoder itself; modport slave is the surrounding
// environment (dense source plus triplet sink).
interface smm_coo_tx_if;
  logic        in_valid_size;
  logic        in_size;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_val;
  logic        out_valid_size;
  logic        out_size;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_row;
  logic [4:0]  out_col;
  logic [3:0]  out_val;
  logic        out_last;
  logic [10:0] nnz_cnt;
  logic        done;

  modport master (
    input  in_valid_size, in_size, in_valid, in_val, out_ready,
    output in_ready, out_valid_size, out_size, out_valid, out_row, out_col,
           out_val, out_last, nnz_cnt, done
  );

  modport slave (
    output in_valid_size, in_size, in_valid, in_val, out_ready,
    input  in_ready, out_valid_size, out_size, out_valid, out_row, out_col,
           out_val, out_last, nnz_cnt, done
  );
endinterface

// File: rtl/smm_coo_tx.sv
// smm_coo_tx: dense-to-sparse (COO) stream encoder for the SMM operand ports.
// Accepts a frame size, then a 16x16 or 32x32 dense matrix in raster order (one
// 4-bit element per handshake), and emits each nonzero as a (row, col, val)
// triplet through an elastic FIFO, flagging the final triplet with out_last.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - smm_coo_tx_if.master (dense input, size pulse, triplet output, status)
// Parameters:
//   FIFO_DEPTH - output FIFO entries, power of two, >= 2
// Build option:
//   SMM_COO_TX_TRANSPOSE_EN - when defined, out_row carries the column index and
//   out_col the row index (operand B fed transposed); emission order unchanged.
module smm_coo_tx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  smm_coo_tx_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSize  = 3'd1;
  localparam logic [2:0] StScan  = 3'd2;
  localparam logic [2:0] StFlush = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic            size_q;
  logic [4:0]      row_q, col_q;
  logic            hold_valid_q;
  logic [4:0]      hold_row_q, hold_col_q;
  logic [3:0]      hold_val_q;
  // FIFO entry: {row[4:0], col[4:0], val[3:0], last}
  logic [14:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [10:0]     nnz_q;

  logic [4:0]  max_idx;
  logic        fifo_full, fifo_empty;
  logic        accept, nonzero, last_elem;
  logic        push, pop;
  logic [14:0] push_data;
  logic [14:0] head;

  assign max_idx    = size_q ? 5'd31 : 5'd15;
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign accept     = (state_q == StScan) && !fifo_full && bus.in_valid;
  assign nonzero    = (bus.in_val != 4'd0);
  assign last_elem  = (row_q == max_idx) && (col_q == max_idx);
  assign pop        = !fifo_empty && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = {hold_row_q, hold_col_q, hold_val_q, 1'b0};
    case (state_q)
      StIdle:  if (bus.in_valid_size) state_d = StSize;
      StSize:  state_d = StScan;
      StScan: begin
        // A new nonzero displaces the held one, which is known not to be last.
        if (accept && nonzero && hold_valid_q) push = 1'b1;
        if (accept && last_elem) state_d = StFlush;
      end
      StFlush: begin
        if (!hold_valid_q) begin
          state_d = StDrain;
        end else if (!fifo_full) begin
          push         = 1'b1;
          push_data[0] = 1'b1;
          state_d      = StDrain;
        end
      end
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      size_q       <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_row_q   <= '0;
      hold_col_q   <= '0;
      hold_val_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      nnz_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.in_valid_size) begin
        size_q       <= bus.in_size;
        row_q        <= '0;
        col_q        <= '0;
        hold_valid_q <= 1'b0;
        nnz_q        <= '0;
      end
      if (accept) begin
        if (col_q == max_idx) begin
          col_q <= '0;
          row_q <= row_q + 5'd1;
        end else begin
          col_q <= col_q + 5'd1;
        end
        if (nonzero) begin
          hold_valid_q <= 1'b1;
          hold_row_q   <= row_q;
          hold_col_q   <= col_q;
          hold_val_q   <= bus.in_val;
        end
      end
      if (state_q == StFlush && push) hold_valid_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        nnz_q    <= nnz_q + 11'd1;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: entries are only read while count_q is nonzero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.in_ready       = (state_q == StScan) && !fifo_full;
  assign bus.out_valid_size = (state_q == StSize);
  assign bus.out_size       = (state_q == StSize) ? size_q : 1'b0;
  assign bus.out_valid      = !fifo_empty;
`ifdef SMM_COO_TX_TRANSPOSE_EN
  assign bus.out_row        = fifo_empty ? 5'd0 : head[9:5];
  assign bus.out_col        = fifo_empty ? 5'd0 : head[14:10];
`else
  assign bus.out_row        = fifo_empty ? 5'd0 : head[14:10];
  assign bus.out_col        = fifo_empty ? 5'd0 : head[9:5];
`endif
  assign bus.out_val        = fifo_empty ? 4'd0 : head[4:1];
  assign bus.out_last       = fifo_empty ? 1'b0 : head[0];
  assign bus.nnz_cnt        = nnz_q;
  assign bus.done           = (state_q == StDone);

endmodule

// File: tb/tb_smm_coo_tx.sv
// tb_smm_coo_tx: directed self-checking bench for smm_coo_tx (FIFO_DEPTH = 4).
// A negedge monitor records triplet handshakes, size pulses and done pulses;
// each test task drives a frame and compares the record against hand-computed
// values.
module tb_smm_coo_tx;

  logic clk;
  logic rst;
  smm_coo_tx_if bus ();

  smm_coo_tx #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  dense [1024];
  int          acc_cnt;

  // Monitor record; beat = {row, col, val, last}
  logic [14:0] beats [$];
  int          size_pulses;
  logic        last_size;
  int          done_cnt;
  logic [10:0] nnz_at_done;
  int          zero_viol;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready)
        beats.push_back({bus.out_row, bus.out_col, bus.out_val, bus.out_last});
      if (bus.out_valid_size) begin
        size_pulses++;
        last_size = bus.out_size;
      end
      if (bus.done) begin
        done_cnt++;
        nnz_at_done = bus.nnz_cnt;
      end
      if (!bus.out_valid && (bus.out_row != 0 || bus.out_col != 0 || bus.out_val != 0 ||
                             bus.out_last != 0))
        zero_viol++;
    end
  end

  task automatic clear_mon();
    beats.delete();
    size_pulses = 0;
    last_size   = 1'b0;
    done_cnt    = 0;
    nnz_at_done = '0;
  endtask

  task automatic clear_dense();
    for (int i = 0; i < 1024; i++) dense[i] = 4'd0;
  endtask

  task automatic drive_size(input logic sz);
    @(posedge clk); #1;
    acc_cnt           = 0;
    bus.in_valid_size = 1'b1;
    bus.in_size       = sz;
    @(posedge clk); #1;
    bus.in_valid_size = 1'b0;
    bus.in_size       = 1'b0;
  endtask

  task automatic drive_elems(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      bus.in_valid = 1'b1;
      bus.in_val   = dense[i];
      w = 0;
      while (1) begin
        @(negedge clk);
        if (bus.in_ready) break;
        w++;
        if (w > 3000) begin
          n_checks++;
          n_fail++;
          $display("FAIL in_ready_timeout: element %0d never accepted, required acceptance", i);
          bus.in_valid = 1'b0;
          bus.in_val   = 4'd0;
          return;
        end
      end
      @(posedge clk); #1;
      acc_cnt++;
    end
    bus.in_valid = 1'b0;
    bus.in_val   = 4'd0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (done_cnt == 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL done_timeout: done never seen, required one pulse");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_valid_size, bus.done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {bus.in_ready, bus.out_valid, bus.out_valid_size, bus.done});
    end
    n_checks++;
    if (bus.nnz_cnt !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_nnz: got %0d required 0", bus.nnz_cnt);
    end
  endtask

  task automatic test_all_zero();
    clear_mon();
    clear_dense();
    bus.out_ready = 1'b1;
    drive_size(1'b0);
    drive_elems(256);
    wait_done();
    n_checks++;
    if (size_pulses !== 1 || last_size !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_size_pulse: got %0d pulses size %0d required 1 pulse size 0",
               size_pulses, last_size);
    end
    n_checks++;
    if (beats.size() !== 0) begin
      n_fail++;
      $display("FAIL zero_beats: got %0d beats required 0", beats.size());
    end
    n_checks++;
    if (done_cnt !== 1 || nnz_at_done !== 11'd0) begin
      n_fail++;
      $display("FAIL zero_done: got %0d done nnz %0d required 1 done nnz 0",
               done_cnt, nnz_at_done);
    end
  endtask

  task automatic test_single();
    logic [14:0] exp;
`ifdef SMM_COO_TX_TRANSPOSE_EN
    exp = {5'd7, 5'd3, 4'd9, 1'b1};
`else
    exp = {5'd3, 5'd7, 4'd9, 1'b1};
`endif
    clear_mon();
    clear_dense();
    dense[3*16+7] = 4'd9;
    bus.out_ready = 1'b1;
    drive_size(1'b0);
    drive_elems(256);
    wait_done();
    n_checks++;
    if (beats.size() !== 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d beats required 1", beats.size());
    end else begin
      n_checks++;
      if (beats[0] !== exp) begin
        n_fail++;
        $display("FAIL single_beat: got %h required %h", beats[0], exp);
      end
    end
    n_checks++;
    if (nnz_at_done !== 11'd1 || bus.nnz_cnt !== 11'd1) begin
      n_fail++;
      $display("FAIL single_nnz: got %0d at done, %0d after, required 1",
               nnz_at_done, bus.nnz_cnt);
    end
  endtask

  task automatic test_size32();
    clear_mon();
    clear_dense();
    dense[0]    = 4'd1;
    dense[1023] = 4'd15;
    bus.out_ready = 1'b1;
    drive_size(1'b1);
    drive_elems(1024);
    wait_done();
    n_checks++;
    if (size_pulses !== 1 || last_size !== 1'b1) begin
      n_fail++;
      $display("FAIL s32_size_pulse: got %0d pulses size %0d required 1 pulse size 1",
               size_pulses, last_size);
    end
    n_checks++;
    if (beats.size() !== 2) begin
      n_fail++;
      $display("FAIL s32_count: got %0d beats required 2", beats.size());
    end else begin
      n_checks++;
      if (beats[0] !== {5'd0, 5'd0, 4'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL s32_beat0: got %h required %h", beats[0], {5'd0, 5'd0, 4'd1, 1'b0});
      end
      n_checks++;
      if (beats[1] !== {5'd31, 5'd31, 4'd15, 1'b1}) begin
        n_fail++;
        $display("FAIL s32_beat1: got %h required %h", beats[1], {5'd31, 5'd31, 4'd15, 1'b1});
      end
    end
    n_checks++;
    if (nnz_at_done !== 11'd2) begin
      n_fail++;
      $display("FAIL s32_nnz: got %0d required 2", nnz_at_done);
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    clear_dense();
    for (int i = 0; i < 16; i++) dense[i*16+i] = 4'd5;
    bus.out_ready = 1'b0;
    fork
      begin
        drive_size(1'b0);
        drive_elems(256);
      end
      begin
        int low_run;
        int w;
        low_run = 0;
        w = 0;
        while (low_run < 6 && w < 1000) begin
          @(negedge clk);
          w++;
          if (acc_cnt > 0 && !bus.in_ready) low_run++;
          else low_run = 0;
        end
        // Hold load of (0,0) plus four pushes: stall follows element 68.
        n_checks++;
        if (acc_cnt !== 69 || bus.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_stall: got %0d accepted in_ready %b, required 69 accepted in_ready 0",
                   acc_cnt, bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_row !== 5'd0 || bus.out_col !== 5'd0) begin
          n_fail++;
          $display("FAIL bp_head: got valid %b row %0d col %0d required valid 1 row 0 col 0",
                   bus.out_valid, bus.out_row, bus.out_col);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done();
    n_checks++;
    if (beats.size() !== 16) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats required 16", beats.size());
    end
    for (int i = 0; i < 16 && i < beats.size(); i++) begin
      logic [14:0] exp;
      exp = {5'(i), 5'(i), 4'd5, (i == 15)};
      n_checks++;
      if (beats[i] !== exp) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h required %h", i, beats[i], exp);
      end
    end
    n_checks++;
    if (nnz_at_done !== 11'd16) begin
      n_fail++;
      $display("FAIL bp_nnz: got %0d required 16", nnz_at_done);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    clear_dense();
    dense[0] = 4'd1;
    dense[1] = 4'd2;
    dense[2] = 4'd3;
    dense[3] = 4'd4;
    bus.out_ready = 1'b0;
    drive_size(1'b0);
    drive_elems(5);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got valid %b ready %b required 1 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_valid_size, bus.out_size, bus.out_last,
         bus.done} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_ctrl: got %b required 000000",
               {bus.in_ready, bus.out_valid, bus.out_valid_size, bus.out_size, bus.out_last,
                bus.done});
    end
    n_checks++;
    if (bus.out_row !== 5'd0 || bus.out_col !== 5'd0 || bus.out_val !== 4'd0 ||
        bus.nnz_cnt !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_fields: got row %0d col %0d val %0d nnz %0d required all 0",
               bus.out_row, bus.out_col, bus.out_val, bus.nnz_cnt);
    end
    clear_mon();
    clear_dense();
    dense[1] = 4'd2;
    bus.out_ready = 1'b1;
    drive_size(1'b0);
    drive_elems(256);
    wait_done();
    n_checks++;
    if (beats.size() !== 1) begin
      n_fail++;
      $display("FAIL mid_count: got %0d beats required 1", beats.size());
    end else begin
      logic [14:0] exp;
`ifdef SMM_COO_TX_TRANSPOSE_EN
      exp = {5'd1, 5'd0, 4'd2, 1'b1};
`else
      exp = {5'd0, 5'd1, 4'd2, 1'b1};
`endif
      n_checks++;
      if (beats[0] !== exp) begin
        n_fail++;
        $display("FAIL mid_beat: got %h required %h", beats[0], exp);
      end
    end
    n_checks++;
    if (zero_viol !== 0) begin
      n_fail++;
      $display("FAIL idle_fields: got %0d cycles with nonzero fields, required 0", zero_viol);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.in_valid_size = 1'b0;
    bus.in_size       = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_val        = 4'd0;
    bus.out_ready     = 1'b0;
    acc_cnt           = 0;
    zero_viol         = 0;
    clear_mon();
    clear_dense();
    test_reset();
    test_all_zero();
    test_single();
    test_size32();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
